// File: rtl/fwd_pkg.sv
// fwd_pkg: shared types for the forwarding/stall controller.
// Forward-select codes, result kinds, stage entries and Tnew lookup.
package fwd_pkg;

  typedef enum logic [1:0] {
    SRC_PC8 = 2'd0,
    SRC_ALU = 2'd1,
    SRC_MEM = 2'd2
  } src_t;

  typedef enum logic [1:0] {
    STG_E = 2'd0,
    STG_M = 2'd1,
    STG_W = 2'd2
  } stg_t;

  localparam logic [2:0] FWD_PC8_M = 3'b000;
  localparam logic [2:0] FWD_ALU_M = 3'b001;
  localparam logic [2:0] FWD_RES_W = 3'b010;
  localparam logic [2:0] FWD_NONE  = 3'b011;

  typedef struct packed {
    logic [4:0] a3;
    src_t       src;
  } ent_t;

  localparam ent_t ENT_NOP = '{a3: 5'd0, src: SRC_ALU};

  function automatic logic [1:0] tnew(
    input stg_t stg,
    input src_t src
  );
    logic [1:0] t;
    t = 2'd0;
    unique case (1'b1)
      stg == STG_E && src == SRC_ALU: t = 2'd1;
      stg == STG_E && src == SRC_MEM: t = 2'd2;
      stg == STG_M && src == SRC_MEM: t = 2'd1;
      default:                        t = 2'd0;
    endcase
    return t;
  endfunction

  function automatic logic hit(
    input logic [4:0] rn,
    input logic [4:0] a3
  );
    return rn != 5'd0 && rn == a3;
  endfunction

endpackage

// File: rtl/fwd_ctrl_if.sv
// fwd_ctrl_if: decode info from D into the controller,
// forward selects and stall back out to the datapath.
interface fwd_ctrl_if;

  logic [4:0] rs_D;
  logic [4:0] rt_D;
  logic [1:0] tuse_rs_D;
  logic [1:0] tuse_rt_D;
  logic [4:0] a3_D;
  logic [1:0] src_D;
  logic [2:0] FSel1_D;
  logic [2:0] FSel2_D;
  logic [2:0] FSel1_E;
  logic [2:0] FSel2_E;
  logic       stall;

  modport master (
    output rs_D, rt_D, tuse_rs_D, tuse_rt_D,
    output a3_D, src_D,
    input  FSel1_D, FSel2_D, FSel1_E, FSel2_E,
    input  stall
  );

  modport slave (
    input  rs_D, rt_D, tuse_rs_D, tuse_rt_D,
    input  a3_D, src_D,
    output FSel1_D, FSel2_D, FSel1_E, FSel2_E,
    output stall
  );

endinterface

// File: rtl/fwd_sel.sv
// fwd_sel: picks the forward source for one operand register.
// M wins over W; M forwards only once its result is ready.
module fwd_sel
  import fwd_pkg::*;
(
  input  logic [4:0] rn,
  input  ent_t       ent_m,
  input  logic [4:0] a3_w,
  output logic [2:0] sel
);

  logic use_m;
  logic use_w;

  assign use_m = hit(rn, ent_m.a3)
              && tnew(STG_M, ent_m.src) == 2'd0;
  assign use_w = !use_m && hit(rn, a3_w);

  always_comb begin
    sel = FWD_NONE;
    unique case (1'b1)
      use_m: begin
        sel = (ent_m.src == SRC_PC8)
            ? FWD_PC8_M : FWD_ALU_M;
      end
      use_w:   sel = FWD_RES_W;
      default: sel = FWD_NONE;
    endcase
  end

endmodule

// File: rtl/fwd_ctrl.sv
// fwd_ctrl: tracks E/M/W destinations and result kinds,
// drives D/E forward selects and the load-use stall.
module fwd_ctrl
  import fwd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  fwd_ctrl_if.slave  bus
);

  ent_t       ent_d;
  ent_t       ent_e;
  ent_t       ent_m;
  logic [4:0] a3_w;
  logic [4:0] rs_E;
  logic [4:0] rt_E;
  logic       stall;
  logic       stall_rs;
  logic       stall_rt;

  assign ent_d = '{a3: bus.a3_D, src: src_t'(bus.src_D)};

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_e <= ENT_NOP;
      ent_m <= ENT_NOP;
      a3_w  <= 5'd0;
      rs_E  <= 5'd0;
      rt_E  <= 5'd0;
    end else begin
      a3_w  <= ent_m.a3;
      ent_m <= ent_e;
      if (stall) begin
        ent_e <= ENT_NOP;
        rs_E  <= 5'd0;
        rt_E  <= 5'd0;
      end else begin
        ent_e <= ent_d;
        rs_E  <= bus.rs_D;
        rt_E  <= bus.rt_D;
      end
    end
  end

  // The youngest producer decides: an E hit hides any M hit.
  function automatic logic need_stall(
    input logic [4:0] rn,
    input logic [1:0] tuse,
    input ent_t       e,
    input ent_t       m
  );
    logic he;
    logic hm;
    he = hit(rn, e.a3);
    hm = hit(rn, m.a3);
    if (he) return tnew(STG_E, e.src) > tuse;
    return hm && tnew(STG_M, m.src) > tuse;
  endfunction

  assign stall_rs = need_stall(bus.rs_D, bus.tuse_rs_D,
                               ent_e, ent_m);
  assign stall_rt = need_stall(bus.rt_D, bus.tuse_rt_D,
                               ent_e, ent_m);
  assign stall    = stall_rs | stall_rt;
  assign bus.stall = stall;

  fwd_sel u_sel1_d (
    .rn    (bus.rs_D),
    .ent_m (ent_m),
    .a3_w  (a3_w),
    .sel   (bus.FSel1_D)
  );

  fwd_sel u_sel2_d (
    .rn    (bus.rt_D),
    .ent_m (ent_m),
    .a3_w  (a3_w),
    .sel   (bus.FSel2_D)
  );

  fwd_sel u_sel1_e (
    .rn    (rs_E),
    .ent_m (ent_m),
    .a3_w  (a3_w),
    .sel   (bus.FSel1_E)
  );

  fwd_sel u_sel2_e (
    .rn    (rt_E),
    .ent_m (ent_m),
    .a3_w  (a3_w),
    .sel   (bus.FSel2_E)
  );

endmodule

// File: tb/tb_fwd_ctrl.sv
// tb_fwd_ctrl: directed per-cycle vectors for fwd_ctrl,
// plus a reset-during-stall sequence.
module tb_fwd_ctrl;
  import fwd_pkg::*;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] urs;
    logic [1:0] urt;
    logic [4:0] a3;
    logic [1:0] src;
    logic [2:0] f1d;
    logic [2:0] f2d;
    logic [2:0] f1e;
    logic [2:0] f2e;
    logic       st;
  } vec_t;

  localparam logic [2:0] N = 3'b011;
  localparam logic [2:0] A = 3'b001;
  localparam logic [2:0] W = 3'b010;
  localparam logic [2:0] P = 3'b000;

  localparam logic [1:0] K_PC8 = 2'd0;
  localparam logic [1:0] K_ALU = 2'd1;
  localparam logic [1:0] K_MEM = 2'd2;

  logic clk = 1'b0;
  logic reset;
  int   n_run  = 0;
  int   n_fail = 0;
  vec_t vq[$];

  fwd_ctrl_if bus ();

  fwd_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [1:0] urs, input logic [1:0] urt,
    input logic [4:0] a3, input logic [1:0] src,
    input logic [2:0] f1d, input logic [2:0] f2d,
    input logic [2:0] f1e, input logic [2:0] f2e,
    input logic st
  );
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
    v.a3 = a3; v.src = src;
    v.f1d = f1d; v.f2d = f2d;
    v.f1e = f1e; v.f2e = f2e; v.st = st;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.rs_D      = v.rs;
    bus.rt_D      = v.rt;
    bus.tuse_rs_D = v.urs;
    bus.tuse_rt_D = v.urt;
    bus.a3_D      = v.a3;
    bus.src_D     = v.src;
  endtask

  task automatic chk(input string nm,
                     input logic [2:0] act,
                     input logic [2:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " FSel1_D"}, bus.FSel1_D, v.f1d);
    chk({tag, " FSel2_D"}, bus.FSel2_D, v.f2d);
    chk({tag, " FSel1_E"}, bus.FSel1_E, v.f1e);
    chk({tag, " FSel2_E"}, bus.FSel2_E, v.f2e);
    chk({tag, " stall"}, {2'b0, bus.stall}, {2'b0, v.st});
  endtask

  initial begin
    vec_t idle;
    vec_t v;
    idle = mk(0, 0, 3, 3, 0, K_ALU, N, N, N, N, 0);
    // after reset
    repeat (3) vq.push_back(mk(8, 9, 1, 1, 0, K_ALU, N, N, N, N, 0));
    // addu $8 ; subu rs=8 ; two readers of $8
    vq.push_back(mk(0, 0, 3, 3, 8, K_ALU, N, N, N, N, 0));
    vq.push_back(mk(8, 0, 1, 1, 10, K_ALU, N, N, N, N, 0));
    vq.push_back(mk(8, 0, 1, 1, 0, K_ALU, A, N, A, N, 0));
    vq.push_back(mk(8, 0, 1, 1, 0, K_ALU, W, N, W, N, 0));
    vq.push_back(idle);
    // lw $9 ; addu rt=9 (one bubble)
    vq.push_back(mk(0, 0, 3, 3, 9, K_MEM, N, N, N, N, 0));
    vq.push_back(mk(0, 9, 3, 1, 11, K_ALU, N, N, N, N, 1));
    vq.push_back(mk(0, 9, 3, 1, 11, K_ALU, N, N, N, N, 0));
    vq.push_back(mk(0, 0, 3, 3, 0, K_ALU, N, N, N, W, 0));
    vq.push_back(idle);
    // lw $9 ; beq rs=9 (two bubbles)
    vq.push_back(mk(0, 0, 3, 3, 9, K_MEM, N, N, N, N, 0));
    vq.push_back(mk(9, 0, 0, 0, 0, K_ALU, N, N, N, N, 1));
    vq.push_back(mk(9, 0, 0, 0, 0, K_ALU, N, N, N, N, 1));
    vq.push_back(mk(9, 0, 0, 0, 0, K_ALU, W, N, N, N, 0));
    vq.push_back(idle);
    // jal ; addu rs=31
    vq.push_back(mk(0, 0, 3, 3, 31, K_PC8, N, N, N, N, 0));
    vq.push_back(mk(31, 0, 1, 1, 12, K_ALU, N, N, N, N, 0));
    vq.push_back(mk(0, 0, 3, 3, 0, K_ALU, N, N, P, N, 0));
    // write to $0, then $0 readers
    vq.push_back(mk(0, 0, 3, 3, 0, K_ALU, N, N, N, N, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, K_ALU, N, N, N, N, 0));
    vq.push_back(idle);
    // addu $8 ; ori $8 ; reader of $8
    vq.push_back(mk(0, 0, 3, 3, 8, K_ALU, N, N, N, N, 0));
    vq.push_back(mk(0, 0, 3, 3, 8, K_ALU, N, N, N, N, 0));
    vq.push_back(mk(8, 0, 1, 1, 0, K_ALU, A, N, N, N, 0));
    vq.push_back(mk(0, 0, 3, 3, 0, K_ALU, N, N, A, N, 0));
    vq.push_back(idle);
    // lw $13 ; sw rt=13 (tuse 2, no stall)
    vq.push_back(mk(0, 0, 3, 3, 13, K_MEM, N, N, N, N, 0));
    vq.push_back(mk(0, 13, 1, 2, 0, K_ALU, N, N, N, N, 0));
    vq.push_back(mk(0, 0, 3, 3, 0, K_ALU, N, N, N, N, 0));

    reset = 1'b1;
    drive(idle);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i]);
      #1;
      chk_all($sformatf("v%0d", i), vq[i]);
    end

    // reset during a load-use stall
    @(negedge clk);
    drive(mk(0, 0, 3, 3, 9, K_MEM, N, N, N, N, 0));
    @(negedge clk);
    v = mk(0, 9, 3, 1, 11, K_ALU, N, N, N, N, 1);
    drive(v);
    #1;
    chk_all("rst_pre", v);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    v.st = 1'b0;
    chk_all("rst_post", v);
    @(negedge clk);
    #1;
    chk_all("rst_next", v);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_ctrl.md
# fwd_ctrl

Forwarding and stall controller for the five-stage pipeline. It tracks the destination register and result source of every in-flight instruction in E, M and W, and drives the forward-select codes consumed by the D-stage comparator muxes and the E-stage ALU operand muxes. It also issues the stall/bubble signal when an operand cannot be forwarded in time. It sits beside the D/E pipeline register and receives decode information for the instruction currently in D.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  pipeline clock
- `reset`  in  1  synchronous, active-high; clears all tracked stage state
- `rs_D`  in  5  rs field of the instruction in D
- `rt_D`  in  5  rt field of the instruction in D
- `tuse_rs_D`  in  2  cycles after D until rs is consumed (0 = branch compare in D, 1 = ALU in E, 2 = store data in M; 3 = unused)
- `tuse_rt_D`  in  2  same for rt
- `a3_D`  in  5  destination register of the instruction in D (0 = no write)
- `src_D`  in  2  result kind: `SRC_PC8`, `SRC_ALU` or `SRC_MEM`
- `FSel1_D`, `FSel2_D`  out  3  forward selects for the D-stage rs/rt compare operands
- `FSel1_E`, `FSel2_E`  out  3  forward selects for the E-stage rs/rt operands
- `stall`  out  1  freeze PC and the F/D register; insert a bubble into E

## Operation
- Forward-select encoding: `3'b000` = M-stage PC+8 (PC4_M+4), `3'b001` = ALUOUT_M, `3'b010` = Result_W, `3'b011` = register-file value (no forward).
- Internal per-stage entry for E, M and W: {a3, src}. On each edge: W<=M, M<=E, and E<=D-inputs, or E<=bubble {0, SRC_ALU} when `stall`=1. `rs_E`/`rt_E` are registered alongside E and cleared on a bubble.
- Tnew by stage and kind:
  - E: PC8 0, ALU 1, MEM 2
  - M: PC8 0, ALU 0, MEM 1
  - W: 0 for all kinds
- A match requires `reg != 0` and `reg == a3` of the stage.
- Forward rule for an operand reg: if it matches M and Tnew_M=0, select 000 (PC8) or 001 (ALU). Else if it matches W, select 010. Else 011. M has priority over W.
- A D-stage operand is never forwarded from E; such a case resolves through stall.
- Stall rule: `stall`=1 iff, for rs or rt of D with a nonzero match, `Tnew_E > tuse` (match E), or `Tnew_M > tuse` (match M and no E match). The youngest producer governs: an E match masks M.
- An M match with kind MEM at Tnew_M=1 and tuse≥1 does not stall; the operand gets 010 one cycle later from E.

## Timing
- All outputs are combinational from the registered stage state and the current D inputs; there are no output registers.
- Stage state updates on the rising edge of `clk`.
- Reset: every entry becomes {0, SRC_ALU}, `rs_E`/`rt_E` = 0. After reset, all FSel outputs = `3'b011` and `stall`=0.
- Reset asserted mid-stall clears the stall on the next cycle, regardless of the D inputs held.
- A load-use hazard costs exactly one bubble for tuse=1 and two bubbles for tuse=0.
- Repeated stall cycles hold D unchanged; E receives a bubble on each stalled cycle.

## Structure
- Shared package `fwd_pkg`:
  - FSel codes `FWD_PC8_M`, `FWD_ALU_M`, `FWD_RES_W`, `FWD_NONE`
  - src kinds `SRC_PC8`, `SRC_ALU`, `SRC_MEM`
  - Tnew function (stage, kind)
- Sub-module `fwd_sel` is natural: combinational, mapping (reg, M entry, W entry) to a 3-bit code. It is instantiated four times.
- Stage registers and stall logic live in `fwd_ctrl`.

## Test plan
- After reset, D = {rs=8, rt=9, a3=0}: all FSel = 011, stall = 0, for 3 cycles.
- `addu $8` (src ALU) then `subu` using rs=8, tuse=1: next cycle FSel1_E=001. The cycle after that, an instruction in D using $8 gets FSel1_D=010.
- `lw $9` then `addu` using rt=9, tuse=1: stall=1 for exactly one cycle, then FSel2_E=010.
- `lw $9` then `beq` using rs=9, tuse=0: stall=1 for two cycles, then FSel1_D=010.
- `jal` (a3=31, PC8) then `addu` using $31: FSel1_E=000, no stall. Any write with a3=0 never forwards (011).
- `addu $8` followed by `ori $8` (both ALU), then a reader of $8: FSel=001 on the M match, not 010 (younger producer wins). `reset` asserted during a lw-use stall: stall=0 on the next cycle.
